// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-read-port register file.
// Optional feature macro used by regfile_mp: REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_MAX_RD = 8;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear engine for regfile_mp: sweeps clr_ptr over every entry after reset or on request.
// busy is high for the whole sweep and drops on the edge that zeroes the last entry.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output rf_state_e         state,
  output logic [ADDR_W-1:0] clr_ptr,
  output logic              busy
);

  rf_state_e         state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= ptr_nxt;
    end
  end

  // clear_req is only honoured from READY; a request mid-sweep is dropped
  always_comb begin
    state_nxt = state;
    ptr_nxt   = clr_ptr;
    case (state)
      RF_CLEAR: begin
        if (clr_ptr == '1) begin
          state_nxt = RF_READY;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = clr_ptr + 1'b1;
        end
      end
      RF_READY: begin
        if (clear_req) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == RF_CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with clear engine and optional hardwired r0.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_RD        = 2,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD out of range");
  end

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  regfile_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .reset    (reset),
    .clear_req(clear_req),
    .state    (state),
    .clr_ptr  (clr_ptr),
    .busy     (busy)
  );

  // Unknown wr_en must never corrupt the array, hence the case-equality test
  assign wr_ok = (state == RF_READY) && (wr_en === 1'b1) &&
                 !((HARDWIRE_ZERO != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hz;
    logic [DATA_W-1:0] rd_q;

    assign ra = rd_addr[g*ADDR_W +: ADDR_W];
    assign hz = (HARDWIRE_ZERO != 0) && (ra == '0);

    // Contents are undefined until the first sweep ends, so busy masks every port
    always_comb begin
      if (busy || hz) begin
        rd_q = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_ok && (wr_addr == ra)) begin
        rd_q = wr_data;
`endif
      end else begin
        rd_q = mem[ra];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default instance, HARDWIRE_ZERO=0 instance and a 16x8x4 instance.
// Read expectations come from a reference model and travel through a queue until sampled.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nz;
  logic        busy, busy_nz;

  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic        s_busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hz[32];
  logic [31:0] m_nz[32];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  regfile_mp #(.HARDWIRE_ZERO(0)) dut_nz (
    .clk(clk), .reset(reset), .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy_nz)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_s (
    .clk(clk), .reset(reset), .clear_req(clear_req), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .busy(s_busy)
  );

  // Drives one READY-state cycle and queues expected reads: hz port0, hz port1, nz port0, nz port1
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0] ra;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {ra1, ra0};
    for (int p = 0; p < 2; p++) begin
      ra = (p == 0) ? ra0 : ra1;
      if (ra == 5'd0) exp_q.push_back(32'h0);
      else if (BYP && we === 1'b1 && wa == ra) exp_q.push_back(wd);
      else exp_q.push_back(m_hz[ra]);
    end
    for (int p = 0; p < 2; p++) begin
      ra = (p == 0) ? ra0 : ra1;
      if (BYP && we === 1'b1 && wa == ra) exp_q.push_back(wd);
      else exp_q.push_back(m_nz[ra]);
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (wr_en === 1'b1) begin
      if (wr_addr != 5'd0) m_hz[wr_addr] = wr_data;
      m_nz[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 32; i++) begin
      m_hz[i] = 32'h0;
      m_nz[i] = 32'h0;
    end
  endtask

  task automatic test_reset();
    int cnt, cnt_nz, cnt_s;
    reset = 1'b0; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || busy_nz !== 1'b1 || s_busy !== 1'b1) begin
        bad++; $display("FAIL reset_busy: got %b%b%b want 111", busy, busy_nz, s_busy);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    cnt = 0; cnt_nz = 0; cnt_s = 0;
    for (int i = 0; i < 100; i++) begin
      rd_addr = 10'($urandom); s_rd_addr = 12'($urandom);
      @(negedge clk);
      if (busy) cnt++;
      if (busy_nz) cnt_nz++;
      if (s_busy) cnt_s++;
      total++;
      if (rd_data !== 64'h0 || rd_data_nz !== 64'h0 || s_rd_data !== 64'h0) begin
        bad++; $display("FAIL sweep_reads_zero: got %h %h %h want 0", rd_data, rd_data_nz, s_rd_data);
      end
      if (!busy && !busy_nz && !s_busy) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++;
    if (cnt != 32 || cnt_nz != 32) begin
      bad++; $display("FAIL sweep_len: got %0d/%0d want 32", cnt, cnt_nz);
    end
    total++;
    if (cnt_s != 8) begin
      bad++; $display("FAIL sweep_len_small: got %0d want 8", cnt_s);
    end
    zero_models();
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    s_wr_en = 1'b1; s_wr_addr = 3'd5; s_wr_data = 16'hBEEF; s_rd_addr = {4{3'd5}};
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
      total++;
      if (g !== e) begin bad++; $display("FAIL wr_r5_same_cycle[%0d]: got %h want %h", p, g, e); end
    end
    commit();
    s_wr_en = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
      total++;
      if (g !== e) begin bad++; $display("FAIL rd_r5[%0d]: got %h want %h", p, g, e); end
    end
    for (int p = 0; p < 4; p++) begin
      total++;
      if (s_rd_data[p*16 +: 16] !== 16'hBEEF) begin
        bad++; $display("FAIL small_rd_r5[%0d]: got %h want beef", p, s_rd_data[p*16 +: 16]);
      end
    end
    commit();
  endtask

  task automatic test_zero_reg();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(1'b1, 5'd0, 32'd55, 5'd0, 5'd0);
      else drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
        total++;
        if (g !== e) begin bad++; $display("FAIL r0_c%0d[%0d]: got %0d want %0d", c, p, g, e); end
      end
      commit();
    end
  endtask

  task automatic test_bypass();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1'b1, 5'd3, 32'h11, 5'd3, 5'd4);
        1: drive(1'b1, 5'd3, 32'hAA, 5'd3, 5'd4);
        default: drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      endcase
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
        total++;
        if (g !== e) begin bad++; $display("FAIL bypass_c%0d[%0d]: got %h want %h", c, p, g, e); end
      end
      commit();
    end
  endtask

  task automatic test_xwrite();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(1'bx, 5'd9, 32'd77, 5'd9, 5'd9);
      else drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
        total++;
        if (g !== e) begin bad++; $display("FAIL x_wr_en_c%0d[%0d]: got %h want %h", c, p, g, e); end
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      if (c < 11) drive(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      else drive(1'b0, 5'd0, 32'h0, 5'($urandom), 5'($urandom));
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        logic [31:0] e, g;
        e = exp_q.pop_front();
        g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
        total++;
        if (g !== e) begin bad++; $display("FAIL b2b_c%0d[%0d]: got %h want %h", c, p, g, e); end
      end
      commit();
    end
  endtask

  task automatic test_clear();
    int cnt;
    drive(1'b1, 5'd7, 32'h1234, 5'd7, 5'd8);
    clear_req = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
      total++;
      if (g !== e) begin bad++; $display("FAIL clr_wr_r7[%0d]: got %h want %h", p, g, e); end
    end
    commit();
    clear_req = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd9; rd_addr = {5'd8, 5'd7};
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        cnt++;
        total++;
        if (rd_data !== 64'h0) begin bad++; $display("FAIL clr_busy_reads: got %h want 0", rd_data); end
      end
      if (!busy && !busy_nz && !s_busy) break;
      @(posedge clk); #1;
      clear_req = (i == 4);
      if (i == 4) wr_en = 1'b0;
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    total++;
    if (cnt != 32) begin bad++; $display("FAIL clr_sweep_len: got %0d want 32", cnt); end
    zero_models();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
      total++;
      if (g !== e) begin bad++; $display("FAIL clr_after[%0d]: got %h want %h", p, g, e); end
    end
    commit();
  endtask

  task automatic test_async_reset();
    int cnt, cnt_s;
    #2 reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || s_busy !== 1'b1) begin
      bad++; $display("FAIL async_reset_busy: got %b%b want 11", busy, s_busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cnt = 0; cnt_s = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      if (s_busy) cnt_s++;
      if (!busy && !busy_nz && !s_busy) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++;
    if (cnt != 32) begin bad++; $display("FAIL restart_sweep_len: got %0d want 32", cnt); end
    total++;
    if (cnt_s != 8) begin bad++; $display("FAIL restart_sweep_small: got %0d want 8", cnt_s); end
    zero_models();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (p < 2) ? rd_data[p*32 +: 32] : rd_data_nz[(p-2)*32 +: 32];
      total++;
      if (g !== e) begin bad++; $display("FAIL restart_cleared[%0d]: got %h want %h", p, g, e); end
    end
    commit();
  endtask

  initial begin
    zero_models();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_xwrite();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
